// File: rtl/scn_sched_pkg.sv
// Shared types and default timing constants for the static-screen draw scheduler.
package scn_sched_pkg;

  localparam int SCN_W = 4;

  localparam int HOLDOFF_CYC_DEF = 34816;
  localparam int SETUP_CYC_DEF   = 4096;
  localparam int PULSE_CYC_DEF   = 4096;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 25000000;

  typedef enum logic [2:0] {
    ST_HOLDOFF,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scn_req_fifo.sv
// Small synchronous request FIFO; DEPTH must be a power of two.
module scn_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/scn_draw_sched.sv
// Round-robin request scheduler and init_draw sequencer for draw_scn.
// Define SCN_SCHED_TIMEOUT_EN to add the done_draw watchdog and err_timeout.
//
// state   | meaning
// HOLDOFF | post-reset LCD hold-off, requests still accepted
// IDLE    | waiting for a queued request; pops head into opt_scn
// SETUP   | opt_scn stable before init_draw
// PULSE   | init_draw high
// WAIT    | waiting for a fresh done_draw rise
// DONE    | one-cycle draw_done_p
module scn_draw_sched
  import scn_sched_pkg::*;
#(
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int PULSE_CYC   = PULSE_CYC_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  input  logic [SCN_W-1:0]            req0_scn,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [SCN_W-1:0]            req1_scn,
  output logic                        req1_ready,
  output logic [SCN_W-1:0]            opt_scn,
  output logic                        init_draw,
  input  logic                        done_draw,
  output logic                        busy,
  output logic [SCN_W-1:0]            cur_scn,
  output logic                        draw_done_p,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef SCN_SCHED_TIMEOUT_EN
  ,
  output logic                        err_timeout
`endif
);

  localparam int CNT_W = $clog2(max3(HOLDOFF_CYC, max3(SETUP_CYC, PULSE_CYC, 1), TIMEOUT_CYC)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
`ifdef SCN_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TOUT_LD  = CNT_W'(TIMEOUT_CYC - 1);
`endif

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [SCN_W-1:0] scn_q, scn_d;
  logic             done_q;
  logic             rr_q;
  logic             done_rise;

  logic             grant0, grant1;
  logic             push, pop;
  logic [SCN_W-1:0] push_scn;
  logic [SCN_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;

`ifdef SCN_SCHED_TIMEOUT_EN
  logic err_q, err_d;
  assign err_timeout = err_q;
`endif

  // rr_q = 1 means requester 1 wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !fifo_full) begin
      if (req0_valid && (!req1_valid || !rr_q)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign push       = grant0 | grant1;
  assign push_scn   = grant0 ? req0_scn : req1_scn;
  assign done_rise  = done_draw & ~done_q;

  scn_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SCN_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_scn),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == '0) ? '0 : tmr_q - CNT_W'(1);
    scn_d   = scn_q;
    pop     = 1'b0;
`ifdef SCN_SCHED_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_HOLDOFF: if (tmr_q == '0) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          scn_d   = fifo_head;
          tmr_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) begin
          tmr_d   = PULSE_LD;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_q == '0) begin
`ifdef SCN_SCHED_TIMEOUT_EN
          tmr_d   = TOUT_LD;
`endif
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_d = ST_DONE;
`ifdef SCN_SCHED_TIMEOUT_EN
        end else if (tmr_q == '0) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_HOLDOFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLDOFF;
      tmr_q   <= HOLD_LD;
      scn_q   <= '0;
      done_q  <= 1'b0;
      rr_q    <= 1'b0;
`ifdef SCN_SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      scn_q   <= scn_d;
      done_q  <= done_draw;
      if (push) rr_q <= grant0;
`ifdef SCN_SCHED_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign opt_scn     = scn_q;
  assign cur_scn     = scn_q;
  assign init_draw   = (state_q == ST_PULSE);
  assign busy        = (state_q != ST_IDLE);
  assign draw_done_p = (state_q == ST_DONE);

endmodule
